// File: rtl/spi_controller.sv
// SPI mode-0 controller: serialises one 16-bit register frame {rw, addr[6:0], data[7:0]}
// MSB-first and returns the last byte seen on CIPO for read frames.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [3:0]  bit_r, bit_s;
  logic        last_r, last_s;
  logic        write_r, write_s;
  logic [15:0] shift_r, shift_s;
  logic [7:0]  rx_r, rx_s;
  logic        cipo_r;
  logic        done_s;
  logic        in_frame_s;

  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [7:0]  rd_data_r;
  logic        busy_r;
  logic        sclk_r;
  logic        ncs_r;
  logic        copi_r;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rd_data   = rd_data_r;
  assign busy      = busy_r;
  assign SCLK      = sclk_r;
  assign nCS       = ncs_r;
  assign COPI      = copi_r;

  // Next-state, phase counter, bit index and shift register update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    last_s  = last_r;
    write_s = write_r;
    shift_s = shift_r;
    rx_s    = rx_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 8'd0;
        if (req_valid) begin
          shift_s = {req_write, req_addr, req_write ? req_wdata : 8'h00};
          write_s = req_write;
          bit_s   = 4'd15;
          last_s  = 1'b0;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s   = 8'd0;
          state_s = HIGH;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      HIGH: begin
        // CIPO was launched on the previous falling edge, so it is stable here
        if (cnt_r == 8'd0) begin
          rx_s = {rx_r[6:0], cipo_r};
        end else begin
          rx_s = rx_r;
        end
        if (cnt_r == DIV_LAST) begin
          cnt_s   = 8'd0;
          state_s = LOW;
          shift_s = {shift_r[14:0], 1'b0};
          if (bit_r == 4'd0) begin
            last_s = 1'b1;
          end else begin
            bit_s = bit_r - 4'd1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      LOW: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s = 8'd0;
          if (last_r) begin
            state_s = GAP;
            done_s  = 1'b1;
          end else begin
            state_s = HIGH;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = 8'd0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    in_frame_s = (state_s == SETUP) || (state_s == HIGH) || (state_s == LOW);
  end

  // State registers; outputs are registered from the next state so pins align with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      bit_r       <= 4'd15;
      last_r      <= 1'b0;
      write_r     <= 1'b0;
      shift_r     <= 16'h0000;
      rx_r        <= 8'h00;
      cipo_r      <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rd_data_r   <= 8'h00;
      busy_r      <= 1'b0;
      sclk_r      <= 1'b0;
      ncs_r       <= 1'b1;
      copi_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_r       <= bit_s;
      last_r      <= last_s;
      write_r     <= write_s;
      shift_r     <= shift_s;
      rx_r        <= rx_s;
      cipo_r      <= CIPO;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= done_s;
      busy_r      <= (state_s != IDLE);
      sclk_r      <= (state_s == HIGH);
      ncs_r       <= ~in_frame_s;
      copi_r      <= in_frame_s & shift_s[15];
      if (done_s && !write_r) begin
        rd_data_r <= rx_r;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: two instances (CLK_DIV=4/CS_GAP=4 and CLK_DIV=2/CS_GAP=1)
// with bus monitors that decode frames, model the peripheral registers and a CIPO responder.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] frame;
    logic [7:0]  rd;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A signals (default timing)
  logic       a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_busy;
  logic       a_sclk, a_ncs, a_copi, a_cipo;
  logic [6:0] a_req_addr;
  logic [7:0] a_req_wdata, a_rd_data;
  // Instance B signals (fastest legal timing)
  logic       b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_busy;
  logic       b_sclk, b_ncs, b_copi, b_cipo;
  logic [6:0] b_req_addr;
  logic [7:0] b_req_wdata, b_rd_data;

  spi_controller #(.CLK_DIV(4), .CS_GAP(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rd_data(a_rd_data), .busy(a_busy),
    .SCLK(a_sclk), .nCS(a_ncs), .COPI(a_copi), .CIPO(a_cipo)
  );

  spi_controller #(.CLK_DIV(2), .CS_GAP(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rd_data(b_rd_data), .busy(b_busy),
    .SCLK(b_sclk), .nCS(b_ncs), .COPI(b_copi), .CIPO(b_cipo)
  );

  assign b_cipo = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] a_regs [128];
  logic [7:0] b_regs [128];
  logic [7:0] a_cipo_byte;
  logic [7:0] a_exp_rd;
  logic       a_gap_exact;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min);
    n_cmp++;
    if (act < min) begin
      n_bad++;
      $display("FAIL %s: actual %0d required >= %0d", name, act, min);
    end
  endtask

  task automatic tfail(input string name, input int waited);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles, required completion within bound", name, waited);
  endtask

  // Monitor A: frame decode, nCS/gap timing, CIPO responder and response scoreboard
  int         a_rises, a_low, a_high;
  logic [15:0] a_bits;
  logic       a_prev_sclk, a_prev_ncs, a_seen;
  logic [2:0] a_idx;
  exp_t       a_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_rises = 0; a_low = 0; a_high = 0; a_bits = 16'h0000;
      a_prev_sclk = 1'b0; a_prev_ncs = 1'b1; a_seen = 1'b0; a_cipo = 1'b0;
    end else begin
      if (a_prev_ncs && !a_ncs) begin
        if (a_seen) begin
          if (a_gap_exact) check("a_gap_exact", 32'(a_high), 32'd5);
          else check_min("a_gap_min", a_high, 5);
        end
        a_rises = 0; a_bits = 16'h0000; a_low = 0;
      end
      if (!a_prev_ncs && a_ncs) begin
        a_seen = 1'b1;
        a_high = 0;
        if (a_rises == 16 && a_bits[15]) a_regs[a_bits[14:8]] = a_bits[7:0];
      end
      if (a_ncs) a_high++;
      else a_low++;
      if (!a_prev_sclk && a_sclk) begin
        a_bits = {a_bits[14:0], a_copi};
        a_rises++;
      end
      if (a_rsp_valid) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_rsp: actual rsp_valid=1 required 0 (no frame pending)");
        end else begin
          a_e = qa.pop_front();
          check("a_frame", 32'(a_bits), 32'(a_e.frame));
          check("a_rises", 32'(a_rises), 32'd16);
          check("a_ncs_low", 32'(a_low), 32'd132);
          check("a_rd_data", 32'(a_rd_data), 32'(a_e.rd));
          check("a_ncs_at_rsp", 32'(a_ncs), 32'd1);
        end
      end
      a_idx = 3'(15 - a_rises);
      a_cipo = (!a_ncs && a_rises >= 8 && a_rises < 16) ? a_cipo_byte[a_idx] : 1'b0;
      a_prev_sclk = a_sclk;
      a_prev_ncs = a_ncs;
    end
  end

  // Monitor B: same decode plus SCLK high/low run lengths
  int         b_rises, b_low, b_high, b_hrun, b_lrun;
  logic [15:0] b_bits;
  logic       b_prev_sclk, b_prev_ncs, b_seen;
  exp_t       b_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_rises = 0; b_low = 0; b_high = 0; b_hrun = 0; b_lrun = 0; b_bits = 16'h0000;
      b_prev_sclk = 1'b0; b_prev_ncs = 1'b1; b_seen = 1'b0;
    end else begin
      if (b_prev_ncs && !b_ncs) begin
        if (b_seen) check("b_gap", 32'(b_high), 32'd2);
        b_rises = 0; b_bits = 16'h0000; b_low = 0; b_lrun = 0; b_hrun = 0;
      end
      if (!b_prev_ncs && b_ncs) begin
        b_seen = 1'b1;
        b_high = 0;
        if (b_rises == 16 && b_bits[15]) b_regs[b_bits[14:8]] = b_bits[7:0];
      end
      if (!b_prev_sclk && b_sclk) begin
        check("b_sclk_low", 32'(b_lrun), 32'd2);
        b_lrun = 0;
        b_bits = {b_bits[14:0], b_copi};
        b_rises++;
      end
      if (b_prev_sclk && !b_sclk) begin
        check("b_sclk_high", 32'(b_hrun), 32'd2);
        b_hrun = 0;
      end
      if (b_ncs) b_high++;
      else b_low++;
      if (b_sclk) b_hrun++;
      else if (!b_ncs) b_lrun++;
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_rsp: actual rsp_valid=1 required 0 (no frame pending)");
        end else begin
          b_e = qb.pop_front();
          check("b_frame", 32'(b_bits), 32'(b_e.frame));
          check("b_rises", 32'(b_rises), 32'd16);
          check("b_ncs_low", 32'(b_low), 32'd66);
          check("b_rd_data", 32'(b_rd_data), 32'(b_e.rd));
        end
      end
      b_prev_sclk = b_sclk;
      b_prev_ncs = b_ncs;
    end
  end

  task automatic issue_a(input logic w, input logic [6:0] ad, input logic [7:0] d,
                         input logic [7:0] cb, input logic hold);
    int t = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
    while (!a_req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      tfail("a_accept", t);
      a_req_valid = 1'b0;
    end else begin
      a_cipo_byte = cb;
      if (!w) a_exp_rd = cb;
      qa.push_back('{frame: {w, ad, (w ? d : 8'h00)}, rd: a_exp_rd});
      @(posedge clk);
      #1;
      if (!hold) a_req_valid = 1'b0;
    end
  endtask

  task automatic issue_b(input logic [6:0] ad, input logic [7:0] d, input logic hold);
    int t = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = ad; b_req_wdata = d;
    while (!b_req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      tfail("b_accept", t);
      b_req_valid = 1'b0;
    end else begin
      qb.push_back('{frame: {1'b1, ad, d}, rd: 8'h00});
      @(posedge clk);
      #1;
      if (!hold) b_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) tfail("drain", t);
  endtask

  initial begin
    exp_t dummy;
    int t;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 7'h00; a_req_wdata = 8'h00;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 7'h00; b_req_wdata = 8'h00;
    a_cipo_byte = 8'h00; a_exp_rd = 8'h00; a_gap_exact = 1'b0;
    for (int i = 0; i < 128; i++) begin
      a_regs[i] = 8'h00;
      b_regs[i] = 8'h00;
    end

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_ncs", 32'(a_ncs), 32'd1);
    check("rst_copi", 32'(a_copi), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rd_data", 32'(a_rd_data), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_b_ncs", 32'(b_ncs), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(a_req_ready), 32'd1);
    check("rst_b_req_ready", 32'(b_req_ready), 32'd1);

    // Single write 0x00 <= 0xA5
    issue_a(1'b1, 7'h00, 8'hA5, 8'h00, 1'b0);
    #1 check("busy_in_frame", 32'(a_busy), 32'd1);
    drain();
    check("reg0_a5", 32'(a_regs[0]), 32'hA5);

    // Five writes with req_valid held high throughout
    issue_a(1'b1, 7'h00, 8'h11, 8'h00, 1'b1);
    issue_a(1'b1, 7'h01, 8'h22, 8'h00, 1'b1);
    a_gap_exact = 1'b1;
    issue_a(1'b1, 7'h02, 8'h33, 8'h00, 1'b1);
    issue_a(1'b1, 7'h03, 8'h44, 8'h00, 1'b1);
    issue_a(1'b1, 7'h04, 8'h55, 8'h00, 1'b0);
    drain();
    a_gap_exact = 1'b0;
    for (int i = 0; i < 5; i++) check("held_reg", 32'(a_regs[i]), 32'(8'h11 * (i + 1)));

    // Read with CIPO responder, then a write that must not disturb rd_data
    issue_a(1'b0, 7'h03, 8'hEE, 8'h3C, 1'b0);
    issue_a(1'b1, 7'h10, 8'h77, 8'h5A, 1'b0);
    drain();
    check("rd_data_kept", 32'(a_rd_data), 32'h3C);

    // Request inputs scrambled after acceptance
    issue_a(1'b1, 7'h2B, 8'hC6, 8'h00, 1'b0);
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      a_req_addr = 7'($urandom);
      a_req_wdata = 8'($urandom);
      a_req_write = 1'($urandom);
    end
    drain();
    check("reg2b_c6", 32'(a_regs[7'h2B]), 32'hC6);

    // Top address, wdata suppressed on reads
    issue_a(1'b0, 7'h7F, 8'hEE, 8'h81, 1'b0);
    drain();

    // Reset while bit 7 is on COPI
    issue_a(1'b1, 7'h12, 8'hB4, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    t = 0;
    while (!(a_rises == 8 && !a_sclk && !a_ncs) && t < 1000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (t >= 1000) tfail("a_bit7_wait", t);
    check("copi_bit7", 32'(a_copi), 32'd1);
    rst_n = 1'b0;
    dummy = qa.pop_back();
    a_exp_rd = 8'h00;
    #1;
    check("abort_ncs", 32'(a_ncs), 32'd1);
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_copi", 32'(a_copi), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_rd_data", 32'(a_rd_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(a_req_ready), 32'd1);
    check("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);

    issue_a(1'b1, 7'h01, 8'hFF, 8'h00, 1'b0);
    drain();
    check("reg1_ff", 32'(a_regs[1]), 32'hFF);
    check("reg12_untouched", 32'(a_regs[7'h12]), 32'h00);

    // Fast instance: two held writes
    issue_b(7'h04, 8'h80, 1'b1);
    issue_b(7'h05, 8'h3C, 1'b0);
    drain();
    check("b_reg4_80", 32'(b_regs[4]), 32'h80);
    check("b_reg5_3c", 32'(b_regs[5]), 32'h3C);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time exceeded, required completion before 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
